conv_window_gen: RTL and testbench
==================================

# conv_window_gen

Streaming 3x3 sliding-window generator sitting directly downstream of the pixel normalizer. Consumes one 16-bit Q8.8 normalized pixel per accepted beat in raster order and emits a complete 3x3 neighbourhood for every interior pixel position. This gives the first convolution layer its input. It uses two row-delay line buffers plus a 3x3 register window. It has no backpressure: the consumer must accept every window.

## Interface

Parameters:
- IMG_W, 28: image width in pixels; minimum 3.
- IMG_H, 28: image height in rows; minimum 3.
- PIX_W, 16: pixel width. Matches the normalizer's Q8.8 output.

Ports:
- clk, input, 1: single clock. All state updates on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- pixel_in, input, PIX_W: normalized pixel from the upstream normalizer.
- valid_in, input, 1: pixel_in is accepted on any rising edge where valid_in=1.
- window_out, output, 9*PIX_W: 3x3 window, flattened.
  - Tap k occupies bits [k*PIX_W +: PIX_W].
  - Tap 0 is top-left, tap 2 is top-right, tap 8 is bottom-right (the newest pixel).
- valid_out, output, 1: window_out holds a new valid window this cycle.
- frame_done, output, 1: one-cycle pulse coincident with the last window of a frame.

## Operation

- Position is tracked by two counters:
  - col counts 0..IMG_W-1 and increments on each accepted pixel.
  - row counts 0..IMG_H-1 and increments when col wraps from IMG_W-1 to 0.
  - row wraps to 0 after the last pixel of the frame.
- Line buffer 0 delays pixel_in by exactly IMG_W accepted beats (the row above). Line buffer 1 delays line buffer 0's output by IMG_W beats (two rows above).
  - Both buffers advance only on accepted beats.
  - Contents are not reset; validity is guaranteed by the row gating below.
- The 3x3 window is three 3-deep shift registers, loaded per accepted beat:
  - bottom row ← pixel_in
  - middle row ← LB0 out
  - top row ← LB1 out
- A window is valid when the accepted pixel has row≥2 and col≥2.
  - No padding is applied.
  - No window spans a row boundary; columns 0 and 1 never produce output.
- Windows per frame = (IMG_W-2)*(IMG_H-2).
- Frames are back-to-back with no gap required.
  - The first window of frame N+1 is produced only at row 2, col 2 of that frame.
  - Stale line-buffer data from frame N is therefore never used.
- Arithmetic: pure data movement, no arithmetic on pixel values. Values pass bit-exact.

## Timing

- Reset values (while rst=0):
  - window_out=0, valid_out=0, frame_done=0.
  - col=0, row=0.
  - Window shift registers cleared.
- Latency: one cycle.
  - valid_out and window_out update on the same edge that accepts the completing pixel.
  - They are visible in the following cycle.
- valid_out is high for exactly one cycle per qualifying accepted pixel. It is low in any cycle after an edge with valid_in=0.
- window_out holds its last value until the next qualifying accept.
- frame_done is high in the same cycle as the valid_out of the window ending at row IMG_H-1, col IMG_W-1.
- Gaps in valid_in: these stall all state. Output is identical to a gapless stream apart from timing.
- Reset mid-frame: asynchronous clear takes effect immediately. The first pixel accepted after release is row 0, col 0.
- No state machine beyond the counters. The implicit phases are:
  - FILL: rows 0-1.
  - STREAM: rows 2..IMG_H-1.
  - The phase returns to FILL at frame wrap.

## Structure

- Shared package cnn_pkg holds:
  - PIX_W.
  - The pixel_t typedef (logic [PIX_W-1:0]).
  - The window_t typedef (pixel_t [8:0]).
  - The tap index constants TAP_TL=0 and TAP_BR=8.
  - The normalizer uses the same package.
- Sub-module line_buffer (parameters DEPTH and PIX_W; ports clk, rst, en, din, dout):
  - Circular register array with a single pointer.
  - Read-before-write on en.
  - dout is the value written DEPTH enables earlier.
  - Instantiated twice.

## Test plan

- **Basic window:** IMG_W=5, IMG_H=4; stream pixel values 0..19 gapless.
  - First valid_out follows pixel 12.
  - window_out taps 0..8 = {0,1,2,5,6,7,10,11,12}.
  - Exactly 6 windows; last = {7,8,9,12,13,14,17,18,19}.
  - frame_done is high with that last window only.
- **Row edges:** same stream.
  - valid_out stays low after pixels 0-11, 15, 16.
  - valid_out is high after pixels 12, 13, 14, 17, 18, 19.
- **Input gaps:** same frame with valid_in dropped every other cycle. The window sequence is identical to the gapless case, and valid_out is never high after an idle edge.
- **Back-to-back frames:** two frames, values 0..19 then 100..119.
  - The second frame's first window = {100,101,102,105,106,107,110,111,112}.
  - No window contains frame-1 data.
- **Mid-frame reset:** assert rst=0 after pixel 8.
  - All outputs read 0 immediately.
  - After release, restream 0..19. Results match the basic-window test exactly.
- **Data integrity:** IMG_W=28, IMG_H=28; feed values 0xFF00, 0x0001, 0x8000 in a pattern.
  - All 676 windows match the golden reference model bit-exact.
  - frame_done pulses once.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared pixel/window types and tap indices for the CNN front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cnn_pkg;

    localparam int PIX_W = 16;

    typedef logic [PIX_W-1:0] pixel_t;
    typedef pixel_t [8:0]     window_t;

    // Tap 0 is the oldest pixel of the top row; tap 8 is the newest pixel.
    localparam int TAP_TL = 0;
    localparam int TAP_BR = 8;

endpackage

// File: rtl/line_buffer.sv
// Row delay line: dout is the value written DEPTH enables earlier.
// Latency: DEPTH enabled beats; read is combinational from the current slot.
// Backpressure: none; advances only when en is high.
module line_buffer #(
    parameter int DEPTH = 28,
    parameter int PIX_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PIX_W-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr;

    // The slot about to be overwritten holds the oldest entry: read-before-write.
    assign dout = mem[ptr];

    // Storage is left unreset; downstream row gating never consumes stale slots.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

    // Single circular pointer, wraps at DEPTH-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator over a raster-order pixel stream, no padding.
// Latency: 1 cycle from the accepting edge of the completing pixel to valid_out.
// Backpressure: none; every accepted beat advances state, consumer must take every window.
module conv_window_gen #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int PIX_W = cnn_pkg::PIX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIX_W-1:0]   pixel_in,
    input  logic               valid_in,
    output logic [9*PIX_W-1:0] window_out,
    output logic               valid_out,
    output logic               frame_done
);

    import cnn_pkg::*;

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]            col;
    logic [RW-1:0]            row;
    logic                     col_last;
    logic                     row_last;
    logic                     qualify;
    logic [PIX_W-1:0]         lb0_dout;
    logic [PIX_W-1:0]         lb1_dout;
    logic [8:0][PIX_W-1:0]    win_q;
    logic [8:0][PIX_W-1:0]    win_nxt;

    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));
    // Rows 0-1 are the fill phase and columns 0-1 would straddle a row edge.
    assign qualify  = valid_in && (row >= RW'(2)) && (col >= CW'(2));

    // LB0 yields the pixel one row above, LB1 the pixel two rows above.
    line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb0 (
        .clk  (clk),
        .rst  (rst),
        .en   (valid_in),
        .din  (pixel_in),
        .dout (lb0_dout)
    );

    line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb1 (
        .clk  (clk),
        .rst  (rst),
        .en   (valid_in),
        .din  (lb0_dout),
        .dout (lb1_dout)
    );

    // Raster position of the pixel being offered; wraps at end of row and frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (valid_in) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Next window: each row shifts toward tap 0 and takes its new column on the right.
    always_comb begin
        win_nxt = win_q;
        for (int r = 0; r < 3; r++) begin
            win_nxt[3*r]     = win_q[3*r + 1];
            win_nxt[3*r + 1] = win_q[3*r + 2];
        end
        win_nxt[TAP_TL + 2] = lb1_dout;
        win_nxt[TAP_TL + 5] = lb0_dout;
        win_nxt[TAP_BR]     = pixel_in;
    end

    // Shift registers move on every accepted beat, qualifying or not.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_q <= '0;
        end else if (valid_in) begin
            win_q <= win_nxt;
        end
    end

    // Output window is captured only on qualifying accepts and held otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            window_out <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= qualify;
            frame_done <= qualify && row_last && col_last;
            if (qualify) begin
                window_out <= win_nxt;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: 5x4 directed table plus 28x28 model-checked frame.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a; stimulus drives valid_in directly.
module tb_conv_window_gen;

    localparam int PW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [PW-1:0]   pix_a = '0;
    logic            vin_a = 1'b0;
    logic [9*PW-1:0] win_a;
    logic            vo_a;
    logic            fd_a;
    logic [PW-1:0]   pix_b = '0;
    logic            vin_b = 1'b0;
    logic [9*PW-1:0] win_b;
    logic            vo_b;
    logic            fd_b;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0]      pix;
        logic             vld;
        logic             dn;
        logic [8:0][15:0] win;
    } vec_t;

    vec_t             tbl [20];
    logic [8:0][15:0] hold_a;
    logic [15:0]      img [784];
    logic [15:0]      pat_v [3];

    always #5 clk = ~clk;

    conv_window_gen #(.IMG_W(5), .IMG_H(4), .PIX_W(PW)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .pixel_in   (pix_a),
        .valid_in   (vin_a),
        .window_out (win_a),
        .valid_out  (vo_a),
        .frame_done (fd_a)
    );

    conv_window_gen #(.IMG_W(28), .IMG_H(28), .PIX_W(PW)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .pixel_in   (pix_b),
        .valid_in   (vin_b),
        .window_out (win_b),
        .valid_out  (vo_b),
        .frame_done (fd_b)
    );

    function automatic logic [8:0][15:0] mk(int a0, int a1, int a2, int a3, int a4,
                                            int a5, int a6, int a7, int a8);
        logic [8:0][15:0] w;
        w[0] = 16'(a0); w[1] = 16'(a1); w[2] = 16'(a2);
        w[3] = 16'(a3); w[4] = 16'(a4); w[5] = 16'(a5);
        w[6] = 16'(a6); w[7] = 16'(a7); w[8] = 16'(a8);
        return w;
    endfunction

    task automatic chk_bit(string nm, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic chk_win(string nm, logic [9*PW-1:0] act, logic [9*PW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_int(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Streams the first n table entries (values offset by off) into dut_a.
    task automatic run_a(string tag, int off, bit gaps, int n);
        logic [8:0][15:0] ew;
        for (int i = 0; i < n; i++) begin
            pix_a = tbl[i].pix + 16'(off);
            vin_a = 1'b1;
            @(posedge clk);
            #1;
            vin_a = 1'b0;
            if (tbl[i].vld) begin
                for (int k = 0; k < 9; k++) ew[k] = tbl[i].win[k] + 16'(off);
                hold_a = ew;
            end
            chk_bit($sformatf("%s vld p%0d", tag, i), vo_a, tbl[i].vld);
            chk_bit($sformatf("%s done p%0d", tag, i), fd_a, tbl[i].dn);
            chk_win($sformatf("%s win p%0d", tag, i), win_a, hold_a);
            if (gaps) begin
                @(posedge clk);
                #1;
                chk_bit($sformatf("%s idle vld p%0d", tag, i), vo_a, 1'b0);
                chk_bit($sformatf("%s idle done p%0d", tag, i), fd_a, 1'b0);
                chk_win($sformatf("%s idle win p%0d", tag, i), win_a, hold_a);
            end
        end
    endtask

    initial begin
        int cnt_v;
        int cnt_d;
        int r;
        int c;
        logic [8:0][15:0] ew;

        // Vector table for the 5x4 frame holding pixel values 0..19.
        for (int i = 0; i < 20; i++) begin
            tbl[i].pix = 16'(i);
            tbl[i].vld = 1'b0;
            tbl[i].dn  = 1'b0;
            tbl[i].win = '0;
        end
        tbl[12].vld = 1'b1; tbl[12].win = mk(0, 1, 2, 5, 6, 7, 10, 11, 12);
        tbl[13].vld = 1'b1; tbl[13].win = mk(1, 2, 3, 6, 7, 8, 11, 12, 13);
        tbl[14].vld = 1'b1; tbl[14].win = mk(2, 3, 4, 7, 8, 9, 12, 13, 14);
        tbl[17].vld = 1'b1; tbl[17].win = mk(5, 6, 7, 10, 11, 12, 15, 16, 17);
        tbl[18].vld = 1'b1; tbl[18].win = mk(6, 7, 8, 11, 12, 13, 16, 17, 18);
        tbl[19].vld = 1'b1; tbl[19].win = mk(7, 8, 9, 12, 13, 14, 17, 18, 19);
        tbl[19].dn  = 1'b1;
        pat_v[0] = 16'hFF00;
        pat_v[1] = 16'h0001;
        pat_v[2] = 16'h8000;
        hold_a = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk_bit("reset vld", vo_a, 1'b0);
        chk_bit("reset done", fd_a, 1'b0);
        chk_win("reset win", win_a, '0);
        rst = 1'b1;

        run_a("basic", 0, 1'b0, 20);
        run_a("gap", 0, 1'b1, 20);
        run_a("b2b", 100, 1'b0, 20);

        // Mid-frame reset after pixel 8, while window_out still holds frame data.
        run_a("pre", 200, 1'b0, 9);
        #2;
        rst = 1'b0;
        #1;
        chk_bit("rst async vld", vo_a, 1'b0);
        chk_bit("rst async done", fd_a, 1'b0);
        chk_win("rst async win", win_a, '0);
        pix_a = 16'hDEAD;
        vin_a = 1'b1;
        @(posedge clk);
        #1;
        vin_a = 1'b0;
        chk_win("rst held win", win_a, '0);
        chk_bit("rst held vld", vo_a, 1'b0);
        rst = 1'b1;
        hold_a = '0;
        run_a("post", 0, 1'b0, 20);

        // Full 28x28 frame against a reference built from the stored image.
        cnt_v = 0;
        cnt_d = 0;
        for (int i = 0; i < 784; i++) begin
            r = i / 28;
            c = i % 28;
            img[i] = pat_v[(2 * i + r) % 3];
            pix_b = img[i];
            vin_b = 1'b1;
            @(posedge clk);
            #1;
            vin_b = 1'b0;
            if (vo_b) cnt_v++;
            if (fd_b) cnt_d++;
            chk_bit($sformatf("big vld p%0d", i), vo_b, (r >= 2) && (c >= 2));
            chk_bit($sformatf("big done p%0d", i), fd_b, i == 783);
            if ((r >= 2) && (c >= 2)) begin
                for (int k = 0; k < 9; k++) begin
                    ew[k] = img[(r - 2 + k / 3) * 28 + (c - 2 + k % 3)];
                end
                chk_win($sformatf("big win p%0d", i), win_b, ew);
            end
        end
        chk_int("big window count", cnt_v, 676);
        chk_int("big done count", cnt_d, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
